// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and defaults for the pipeline stall/flush controller.
package pipe_hazard_ctrl_pkg;

    localparam int ASIZE_DEF   = 5;
    localparam int TIMEOUT_DEF = 64;
    localparam int CNTW_DEF    = 16;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use hazard compare between the EX load and the ID sources.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int ASIZE = ASIZE_DEF
) (
    input  logic [ASIZE-1:0] id_rs,
    input  logic [ASIZE-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [ASIZE-1:0] ex_waddr,
    input  logic             ex_memtoreg,
    input  logic             ex_wen,
    output logic             load_use
);

    logic rs_hit;
    logic rt_hit;

    always_comb begin
        rs_hit   = (ex_waddr == id_rs);
        rt_hit   = id_uses_rt && (ex_waddr == id_rt);
        // Register 0 is hardwired, so a load targeting it never creates a dependency.
        load_use = ex_memtoreg && ex_wen && (ex_waddr != '0) && (rs_hit || rt_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller: load-use, taken branch and multi-cycle data memory.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int ASIZE   = ASIZE_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNTW    = CNTW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ASIZE-1:0] id_rs,
    input  logic [ASIZE-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic [ASIZE-1:0] ex_waddr,
    input  logic             ex_memtoreg,
    input  logic             ex_wen,
    input  logic             branch_taken,
    input  logic             mem_memwrite,
    input  logic             mem_memtoreg,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic [CNTW-1:0]  stall_cycles
);

    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state, state_nxt;
    logic [WW-1:0]   wait_cnt;
    logic [CNTW-1:0] cnt;
    logic            err;
    logic            memop, force_done, mem_hold, load_use;

    hazard_detect #(.ASIZE(ASIZE)) u_hazard_detect (
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .ex_waddr    (ex_waddr),
        .ex_memtoreg (ex_memtoreg),
        .ex_wen      (ex_wen),
        .load_use    (load_use)
    );

    always_comb begin
        memop         = mem_memwrite || mem_memtoreg;
        force_done    = (state == ST_MEM_WAIT) && (wait_cnt == WW'(TIMEOUT - 1));
        mem_hold      = memop && !dmem_ready && !force_done;
        state_nxt     = state;
        dmem_req      = memop && !rst;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_stall  = 1'b0;
        mem_wb_bubble = 1'b0;

        unique case (state)
            ST_RUN:      if (mem_hold) state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: if (dmem_ready || force_done) state_nxt = ST_RUN;
            default:     state_nxt = ST_RUN;
        endcase

        // A taken branch seen while memory holds the pipe is simply deferred:
        // EX is frozen, so branch_taken is still asserted once the hold drops.
        if (!rst) begin
            if (mem_hold) begin
                pc_stall      = 1'b1;
                if_id_stall   = 1'b1;
                id_ex_stall   = 1'b1;
                ex_mem_stall  = 1'b1;
                mem_wb_bubble = 1'b1;
            end else if (branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            err      <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= (state == ST_MEM_WAIT && state_nxt == ST_MEM_WAIT) ? wait_cnt + 1'b1 : '0;
            if (force_done)
                err <= 1'b1;
            if (pc_stall && cnt != '1)
                cnt <= cnt + 1'b1;
        end
    end

    assign mem_err      = err && !rst;
    assign stall_cycles = rst ? '0 : cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int ASIZE   = 5;
    localparam int TIMEOUT = 4;
    localparam int CNTW    = 4;
    localparam int CMAX    = (1 << CNTW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [ASIZE-1:0] id_rs, id_rt, ex_waddr;
    logic             id_uses_rt, ex_memtoreg, ex_wen, branch_taken;
    logic             mem_memwrite, mem_memtoreg, dmem_ready;
    logic             dmem_req, pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic             id_ex_flush, ex_mem_stall, mem_wb_bubble, mem_err;
    logic [CNTW-1:0]  stall_cycles;

    int checks   = 0;
    int failures = 0;

    pipe_hazard_ctrl #(.ASIZE(ASIZE), .TIMEOUT(TIMEOUT), .CNTW(CNTW)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_waddr      (ex_waddr),
        .ex_memtoreg   (ex_memtoreg),
        .ex_wen        (ex_wen),
        .branch_taken  (branch_taken),
        .mem_memwrite  (mem_memwrite),
        .mem_memtoreg  (mem_memtoreg),
        .dmem_ready    (dmem_ready),
        .dmem_req      (dmem_req),
        .pc_stall      (pc_stall),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .id_ex_stall   (id_ex_stall),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_stall  (ex_mem_stall),
        .mem_wb_bubble (mem_wb_bubble),
        .mem_err       (mem_err),
        .stall_cycles  (stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model: counts how long the current access has been waiting,
    // and gives up once that reaches TIMEOUT.
    int   m_waited = 0;
    int   m_cnt    = 0;
    bit   m_err    = 1'b0;
    bit   e_req, e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs, e_bub, e_err;
    int   e_cnt;
    bit   m_memop, m_hold, m_lu;

    always_comb begin
        m_memop = mem_memwrite || mem_memtoreg;
        m_hold  = m_memop && !dmem_ready && (m_waited < TIMEOUT);
        m_lu    = ex_memtoreg && ex_wen && (ex_waddr != 0) &&
                  ((ex_waddr == id_rs) || (id_uses_rt && ex_waddr == id_rt));
        e_req = 0; e_pc = 0; e_ifs = 0; e_iff = 0; e_ids = 0; e_idf = 0; e_exs = 0; e_bub = 0;
        e_err = 0; e_cnt = 0;
        if (!rst) begin
            e_req = m_memop;
            e_err = m_err;
            e_cnt = m_cnt;
            if (m_hold) begin
                e_pc = 1; e_ifs = 1; e_ids = 1; e_exs = 1; e_bub = 1;
            end else if (branch_taken) begin
                e_iff = 1; e_idf = 1;
            end else if (m_lu) begin
                e_pc = 1; e_ifs = 1; e_idf = 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_waited <= 0;
            m_cnt    <= 0;
            m_err    <= 1'b0;
        end else begin
            m_waited <= m_hold ? m_waited + 1 : 0;
            if (m_waited == TIMEOUT) m_err <= 1'b1;
            if (e_pc && m_cnt < CMAX) m_cnt <= m_cnt + 1;
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0d expected=%0d", nm, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("m_dmem_req",      int'(dmem_req),      int'(e_req));
        chk("m_pc_stall",      int'(pc_stall),      int'(e_pc));
        chk("m_if_id_stall",   int'(if_id_stall),   int'(e_ifs));
        chk("m_if_id_flush",   int'(if_id_flush),   int'(e_iff));
        chk("m_id_ex_stall",   int'(id_ex_stall),   int'(e_ids));
        chk("m_id_ex_flush",   int'(id_ex_flush),   int'(e_idf));
        chk("m_ex_mem_stall",  int'(ex_mem_stall),  int'(e_exs));
        chk("m_mem_wb_bubble", int'(mem_wb_bubble), int'(e_bub));
        chk("m_mem_err",       int'(mem_err),       int'(e_err));
        chk("m_stall_cycles",  int'(stall_cycles),  e_cnt);
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = '0; id_rt = '0; id_uses_rt = 0; ex_waddr = '0; ex_memtoreg = 0; ex_wen = 0;
        branch_taken = 0; mem_memwrite = 0; mem_memtoreg = 0; dmem_ready = 0;
    endtask

    task automatic load_ex(input int rd);
        ex_memtoreg = 1; ex_wen = 1; ex_waddr = ASIZE'(rd);
    endtask

    initial begin
        rst = 1'b1;
        clr();
        repeat (3) next();
        @(negedge clk);
        chk("rst_pc_stall", int'(pc_stall), 0);
        chk("rst_stall_cycles", int'(stall_cycles), 0);
        chk("rst_mem_err", int'(mem_err), 0);
        next();
        rst = 1'b0;

        // Zero-wait access in RUN: no stall.
        mem_memtoreg = 1; dmem_ready = 1;
        @(negedge clk);
        chk("zw_dmem_req", int'(dmem_req), 1);
        chk("zw_pc_stall", int'(pc_stall), 0);
        next(); clr();

        // Load-use through rs: one stall cycle, then the bubble clears it.
        load_ex(3); id_rs = 3;
        @(negedge clk);
        chk("lu_rs_pc_stall", int'(pc_stall), 1);
        chk("lu_rs_if_id_stall", int'(if_id_stall), 1);
        chk("lu_rs_id_ex_flush", int'(id_ex_flush), 1);
        next(); clr(); id_rs = 3;
        @(negedge clk);
        chk("lu_rs_after", int'(pc_stall), 0);
        chk("lu_rs_cnt", int'(stall_cycles), 1);
        next(); clr();

        load_ex(0); id_rs = 0;
        @(negedge clk);
        chk("lu_r0_no_stall", int'(pc_stall), 0);
        next(); clr();

        load_ex(3); id_rs = 5; id_rt = 3; id_uses_rt = 0;
        @(negedge clk);
        chk("lu_rt_unused", int'(pc_stall), 0);
        next();
        id_uses_rt = 1;
        @(negedge clk);
        chk("lu_rt_used", int'(pc_stall), 1);
        next();
        ex_wen = 0;
        @(negedge clk);
        chk("lu_no_wen", int'(pc_stall), 0);
        next();
        ex_wen = 1; branch_taken = 1;
        @(negedge clk);
        chk("br_over_lu_pc", int'(pc_stall), 0);
        chk("br_over_lu_flush", int'(if_id_flush), 1);
        next(); clr();

        // Load in MEM, ready arrives on the 4th cycle.
        mem_memtoreg = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("w3_freeze", int'(ex_mem_stall), 1);
            chk("w3_bubble", int'(mem_wb_bubble), 1);
            next();
        end
        dmem_ready = 1;
        @(negedge clk);
        chk("w3_release", int'(pc_stall), 0);
        next(); clr();
        @(negedge clk);
        chk("w3_cnt", int'(stall_cycles), 5);
        next();

        // Taken branch during a 2-cycle store wait: deferred until release.
        mem_memwrite = 1; branch_taken = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("bw_no_flush", int'(if_id_flush), 0);
            chk("bw_pc_stall", int'(pc_stall), 1);
            next();
        end
        dmem_ready = 1;
        @(negedge clk);
        chk("bw_if_flush", int'(if_id_flush), 1);
        chk("bw_id_flush", int'(id_ex_flush), 1);
        chk("bw_pc_free", int'(pc_stall), 0);
        next(); clr();

        // Ready never comes: four freeze cycles then forced completion.
        mem_memtoreg = 1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            chk("to_freeze", int'(pc_stall), 1);
            next();
        end
        @(negedge clk);
        chk("to_forced", int'(pc_stall), 0);
        chk("to_err_pre", int'(mem_err), 0);
        next(); clr();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("to_err_sticky", int'(mem_err), 1);
            next();
        end
        @(negedge clk);
        chk("to_cnt", int'(stall_cycles), 11);
        next();

        // Saturation of the stall counter.
        load_ex(7); id_rs = 7;
        repeat (6) next();
        @(negedge clk);
        chk("sat_cnt", int'(stall_cycles), CMAX);
        next(); clr();

        // Reset in the middle of a wait.
        mem_memtoreg = 1;
        @(negedge clk);
        chk("rw_hold", int'(pc_stall), 1);
        next();
        rst = 1'b1;
        @(negedge clk);
        chk("rw_req_drop", int'(dmem_req), 0);
        chk("rw_pc_drop", int'(pc_stall), 0);
        next();
        rst = 1'b0; mem_memtoreg = 0;
        @(negedge clk);
        chk("rw_cnt_clr", int'(stall_cycles), 0);
        chk("rw_err_clr", int'(mem_err), 0);
        next();
        mem_memtoreg = 1; dmem_ready = 1;
        @(negedge clk);
        chk("rw_state_run", int'(pc_stall), 0);
        next(); clr();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
